handshake_fifo_counted: RTL
===========================

// Module: handshake_fifo_counted
// PURPOSE
//   Parametrised push/pull FIFO with a four-phase req/ack handshake on the write (head) and read (tail) sides.
//   Successor to the 1-bit push/pull FIFO: multi-bit words, explicit occupancy count, full/empty/almostFull
//   flags, ack held for the full handshake, and defined simultaneous/boundary behaviour.
//   Sits between a producer and a consumer counter/stage; both share one clock.
// PARAMETERS
//   FIFO_WORD_SIZE     8  data width in bits (>=1)
//   FIFO_POINTER_BITS  2  log2 of depth; DEPTH = 2**FIFO_POINTER_BITS slots
//   ALMOST_FULL_LEVEL  3  almostFull asserts when count >= this value (1..DEPTH)
// PORTS
//   clock       in   1                    rising-edge clock; sole clock
//   clear       in   1                    synchronous, active-high reset
//   inValue     in   FIFO_WORD_SIZE       write data, sampled with inReq
//   inReq       in   1                    producer request, level, four-phase
//   inAck       out  1                    write accepted; held until inReq falls
//   outReq      in   1                    consumer request, level, four-phase
//   outAck      out  1                    read data valid; held until outReq falls
//   outValue    out  FIFO_WORD_SIZE       read data, registered
//   count       out  FIFO_POINTER_BITS+1  occupancy, 0..DEPTH
//   full        out  1                    count == DEPTH
//   empty       out  1                    count == 0
//   almostFull  out  1                    count >= ALMOST_FULL_LEVEL
// BEHAVIOUR
//   - Reset: clear is sampled on the rising edge of clock only.
//     - inAck=0, outAck=0, outValue=0, count=0, empty=1, full=0, almostFull=0.
//     - Head/tail pointers are 0; stored data is discarded.
//   - Head FSM (WAIT_REQ_HIGH, WAIT_REQ_LOW). Tail FSM has the same two states.
//     - Both FSMs leave reset in WAIT_REQ_LOW, so a req still high across clear is never taken as a new transfer.
//   - Head, WAIT_REQ_HIGH: if inReq && !full at the edge:
//     - buffer[head] <= inValue; head <= head+1 (mod DEPTH); inAck <= 1; go to WAIT_REQ_LOW.
//     - Ack latency: 1 cycle after the req is sampled.
//     - If full, stay in this state with inAck=0; the request stalls until a slot frees.
//   - Head, WAIT_REQ_LOW: inAck stays 1 while inReq=1.
//     - When inReq is sampled 0: inAck <= 0 and go to WAIT_REQ_HIGH.
//     - Minimum transfer period is 2 cycles.
//   - Tail, WAIT_REQ_HIGH: if outReq && !empty:
//     - outValue <= buffer[tail]; tail <= tail+1; outAck <= 1; go to WAIT_REQ_LOW.
//     - If empty, stall with outAck=0.
//   - Tail, WAIT_REQ_LOW: mirrors the head (outAck held until outReq is sampled 0).
//     - outValue holds its last value until the next accepted pull.
//   - Count, flags and arbitration:
//     - count: +1 on write only, -1 on read only, unchanged when a write and a read are both accepted in the same cycle.
//     - full, empty and almostFull are combinational decodes of the registered count.
//     - Acceptance uses the registered count, so there is no fall-through:
//       - pull on empty + push in same cycle: push accepted, pull waits 1 cycle;
//       - push on full + pull in same cycle: pull accepted, push waits 1 cycle.
//   - Pointers wrap silently at DEPTH; full is distinguished from empty by count, not by the pointers.
//   - Overflow and underflow are impossible by construction; no data is ever dropped or duplicated.
//   - clear mid-handshake: acks drop next cycle; data in flight is lost; producer/consumer must deassert req before retrying.
// TESTING
//   1. Reset, then push 8'hA1 (inReq held 3 cycles, then low):
//      inAck=1 from cycle+1 until 1 cycle after inReq falls; count=1; empty=0.
//   2. DEPTH=4: push 1,2,3,4:
//      full=1, almostFull=1 from count 3; a 5th push stalls with inAck=0 until a pull; then pulls return 1,2,3,4 in order.
//   3. Empty FIFO, outReq and inReq both rise in the same cycle:
//      inAck at +1, outAck at +2, outValue=pushed word, count returns to 0.
//   4. Full FIFO, push and pull in the same cycle:
//      pull is accepted first, push 1 cycle later; count goes 4->3->4 and the order is preserved.
//   5. Wrap: 10 push/pull pairs with DEPTH=4; outValue sequence == inValue sequence, count never exceeds 4.
//   6. clear asserted while inAck=1 and inReq is still high:
//      inAck=0, count=0, no new write until inReq is seen low then high again.

Source files
------------

// File: rtl/handshake_fifo_counted.sv
// handshake_fifo_counted
// Counted FIFO with four-phase req/ack handshakes on both the write (head)
// and read (tail) sides. The producer and the consumer share one clock.
// Acceptance decisions use the registered occupancy count, so data never
// falls through in the cycle it is written, and overflow or underflow
// cannot occur.

module handshake_fifo_counted #(
  parameter int FIFO_WORD_SIZE    = 8,
  parameter int FIFO_POINTER_BITS = 2,
  parameter int ALMOST_FULL_LEVEL = 3
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic [FIFO_WORD_SIZE-1:0]    inValue,
  input  logic                         inReq,
  output logic                         inAck,
  input  logic                         outReq,
  output logic                         outAck,
  output logic [FIFO_WORD_SIZE-1:0]    outValue,
  output logic [FIFO_POINTER_BITS:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almostFull
);

  localparam int DEPTH = 1 << FIFO_POINTER_BITS;
  localparam logic [FIFO_POINTER_BITS:0] DEPTH_COUNT = (FIFO_POINTER_BITS + 1)'(DEPTH);
  localparam logic [FIFO_POINTER_BITS:0] ALMOST_COUNT = (FIFO_POINTER_BITS + 1)'(ALMOST_FULL_LEVEL);

  typedef enum logic {
    WAIT_REQ_HIGH = 1'b0,
    WAIT_REQ_LOW  = 1'b1
  } hs_state_t;

  hs_state_t head_state, head_next;
  hs_state_t tail_state, tail_next;

  logic push_accept;
  logic pull_accept;

  logic [FIFO_POINTER_BITS-1:0] head_ptr;
  logic [FIFO_POINTER_BITS-1:0] tail_ptr;
  logic [FIFO_WORD_SIZE-1:0]    buffer [DEPTH];

  // Flags are plain decodes of the registered occupancy.
  assign full       = (count == DEPTH_COUNT);
  assign empty      = (count == '0);
  assign almostFull = (count >= ALMOST_COUNT);

  // Head state register; leaving reset in WAIT_REQ_LOW keeps a stale req from starting a write.
  always_ff @(posedge clock) begin
    if (clear) head_state <= WAIT_REQ_LOW;
    else       head_state <= head_next;
  end

  // Head next-state: take a write on a request when a slot is free, then wait for req to drop.
  always_comb begin
    head_next   = head_state;
    push_accept = 1'b0;
    case (head_state)
      WAIT_REQ_HIGH: begin
        if (inReq && !full) begin
          push_accept = 1'b1;
          head_next   = WAIT_REQ_LOW;
        end
      end
      WAIT_REQ_LOW: begin
        if (!inReq) head_next = WAIT_REQ_HIGH;
      end
      default: head_next = WAIT_REQ_LOW;
    endcase
  end

  // Tail state register; same reset treatment as the head.
  always_ff @(posedge clock) begin
    if (clear) tail_state <= WAIT_REQ_LOW;
    else       tail_state <= tail_next;
  end

  // Tail next-state: hand out a word on a request when data is stored, then wait for req to drop.
  always_comb begin
    tail_next   = tail_state;
    pull_accept = 1'b0;
    case (tail_state)
      WAIT_REQ_HIGH: begin
        if (outReq && !empty) begin
          pull_accept = 1'b1;
          tail_next   = WAIT_REQ_LOW;
        end
      end
      WAIT_REQ_LOW: begin
        if (!outReq) tail_next = WAIT_REQ_HIGH;
      end
      default: tail_next = WAIT_REQ_LOW;
    endcase
  end

  // Write ack rises with an accepted write and falls once req is seen low.
  always_ff @(posedge clock) begin
    if (clear)                                   inAck <= 1'b0;
    else if (push_accept)                        inAck <= 1'b1;
    else if (head_state == WAIT_REQ_LOW && !inReq) inAck <= 1'b0;
  end

  // Read ack and registered read data; outValue holds until the next accepted pull.
  always_ff @(posedge clock) begin
    if (clear) begin
      outAck   <= 1'b0;
      outValue <= '0;
    end else if (pull_accept) begin
      outAck   <= 1'b1;
      outValue <= buffer[tail_ptr];
    end else if (tail_state == WAIT_REQ_LOW && !outReq) begin
      outAck   <= 1'b0;
    end
  end

  // Storage array; contents are not cleared, since the pointers and count make them unreachable.
  always_ff @(posedge clock) begin
    if (push_accept) buffer[head_ptr] <= inValue;
  end

  // Pointers wrap naturally at DEPTH; full and empty are told apart by count.
  always_ff @(posedge clock) begin
    if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push_accept) head_ptr <= head_ptr + 1'b1;
      if (pull_accept) tail_ptr <= tail_ptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous write and read leave it unchanged.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (push_accept && !pull_accept) begin
      count <= count + 1'b1;
    end else if (pull_accept && !push_accept) begin
      count <= count - 1'b1;
    end
  end

endmodule
